// File: rtl/timing_sequencer.sv
// Sequence counter with run/stop control and registered one-hot timing outputs T0..T(N-1).
// Optional sticky wrap_err output enabled by defining TIMING_WRAP_ERR_EN.
module timing_sequencer #(
    parameter int NUM_STATES = 16,
    parameter bit RESET_RUN  = 1'b1,
    localparam int CW = $clog2(NUM_STATES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  clr,
    input  logic                  inc,
    input  logic                  hold,
    output logic [CW-1:0]         sc_value,
    output logic [NUM_STATES-1:0] timing_signals,
    output logic                  running,
    output logic                  wrap
`ifdef TIMING_WRAP_ERR_EN
    ,
    output logic                  wrap_err
`endif
);

    // state | meaning
    // STOP  | sequencer idle, SC held at 0, all T outputs low
    // RUN   | SC advances under clr/hold/inc, exactly one T output high
    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CW-1:0] SC_LAST = CW'(NUM_STATES - 1);
    localparam state_t ST_RESET = RESET_RUN ? ST_RUN : ST_STOP;

    state_t                  state, state_nxt;
    logic [CW-1:0]           sc, sc_nxt;
    logic [NUM_STATES-1:0]   t_q, t_nxt;
    logic                    wrap_q, wrap_nxt;

    always_comb begin
        state_nxt = state;
        sc_nxt    = '0;
        wrap_nxt  = 1'b0;
        case (state)
            ST_STOP: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    state_nxt = ST_STOP;
                end else if (clr) begin
                    sc_nxt = '0;
                end else if (hold) begin
                    sc_nxt = sc;
                end else if (inc) begin
                    if (sc == SC_LAST) begin
                        sc_nxt   = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        sc_nxt = sc + CW'(1);
                    end
                end else begin
                    sc_nxt = sc;
                end
            end
            default: state_nxt = ST_RESET;
        endcase
        // T is decoded from the next SC so it moves on the same edge as sc_value
        t_nxt = (state_nxt == ST_RUN) ? (NUM_STATES'(1) << sc_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_RESET;
            sc     <= '0;
            t_q    <= RESET_RUN ? NUM_STATES'(1) : '0;
            wrap_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            sc     <= sc_nxt;
            t_q    <= t_nxt;
            wrap_q <= wrap_nxt;
        end
    end

`ifdef TIMING_WRAP_ERR_EN
    logic err_q;

    // wrap_nxt already excludes clr, so any inc-driven wrap is an error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == ST_STOP && start) begin
            err_q <= 1'b0;
        end else if (wrap_nxt) begin
            err_q <= 1'b1;
        end
    end

    assign wrap_err = err_q;
`endif

    assign sc_value       = sc;
    assign timing_signals = t_q;
    assign running        = (state == ST_RUN);
    assign wrap           = wrap_q;

endmodule
